// File: rtl/fibo_datapath.sv
// fibo_datapath
//   Datapath for a Fibonacci-sequence generator: a 4-entry register file,
//   an 8-function ALU and a write-data multiplexer selecting between an
//   external load value and the ALU result.
//
// Ports
//   clk         in   1     clock, all state updates on rising edge
//   rst         in   1     synchronous active-high reset, clears R0..R3
//   wrt_addr    in   2     register-file write address
//   wrt_en      in   1     write enable
//   load_data   in   1     write-data select: 1 = count, 0 = ALU result
//   rd_addr1    in   2     read port 1 address (ALU operand A)
//   rd_addr2    in   2     read port 2 address (ALU operand B)
//   alu_opcode  in   3     ALU operation select
//   count       in   size  external load value
//   zero_flag   out  1     ALU result is zero
//   data        out  size  ALU result
module fibo_datapath #(
  parameter int size = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      wrt_addr,
  input  logic            wrt_en,
  input  logic            load_data,
  input  logic [1:0]      rd_addr1,
  input  logic [1:0]      rd_addr2,
  input  logic [2:0]      alu_opcode,
  input  logic [size-1:0] count,
  output logic            zero_flag,
  output logic [size-1:0] data
);

  // Every opcode is decoded, so there is no X-producing default path.
  // Add/subtract wrap modulo 2^size; carry and borrow are dropped.
  function automatic logic [size-1:0] alu_f(
    input logic [2:0]      op,
    input logic [size-1:0] a,
    input logic [size-1:0] b
  );
    logic [size-1:0] r;
    case (op)
      3'b000:  r = a;
      3'b001:  r = b;
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = a ^ b;
      3'b101:  r = ~a;
      3'b110:  r = a + b;
      default: r = a - b;
    endcase
    return r;
  endfunction

  logic [size-1:0] regs_q [4];
  logic [size-1:0] regs_d [4];
  logic [size-1:0] opa, opb, alu_res, wd;

  // Reads come straight from the registers: a write to the same address
  // only becomes visible after the edge.
  assign opa     = regs_q[rd_addr1];
  assign opb     = regs_q[rd_addr2];
  assign alu_res = alu_f(alu_opcode, opa, opb);
  assign wd      = load_data ? count : alu_res;

  always_comb begin
    for (int i = 0; i < 4; i++) regs_d[i] = regs_q[i];
    if (wrt_en) regs_d[wrt_addr] = wd;
  end

  // Register file update; reset wins over a concurrent write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign data      = alu_res;
  assign zero_flag = (alu_res == '0);

endmodule

// File: tb/tb_fibo_datapath.sv
module tb_fibo_datapath;

  logic       clk;
  logic       rst;
  logic [1:0] wrt_addr;
  logic       wrt_en;
  logic       load_data;
  logic [1:0] rd_addr1;
  logic [1:0] rd_addr2;
  logic [2:0] alu_opcode;
  logic [3:0] count;
  logic       zero_flag;
  logic [3:0] data;

  fibo_datapath #(.size(4)) dut (
    .clk(clk), .rst(rst), .wrt_addr(wrt_addr), .wrt_en(wrt_en),
    .load_data(load_data), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .alu_opcode(alu_opcode), .count(count), .zero_flag(zero_flag),
    .data(data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchecks = 0;
  int nerr    = 0;
  int mr [4];  // reference register file contents

  typedef struct {
    logic [2:0] op;
    logic [3:0] exp_data;
    logic       exp_zf;
  } vec_t;
  vec_t vt [8];

  int fib_exp [12];

  // Reference ALU written from the operation definitions with plain integers.
  function automatic int m_alu(int op, int a, int b);
    case (op)
      0: return a;
      1: return b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return 15 - a;
      6: return (a + b) % 16;
      default: return (a - b + 16) % 16;
    endcase
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    nchecks++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Compare both outputs against the reference model for current inputs.
  task automatic chk_model(input string name);
    int r;
    r = m_alu(alu_opcode, mr[rd_addr1], mr[rd_addr2]);
    chk({name, "_data"}, data, r);
    chk({name, "_zf"}, zero_flag, (r == 0) ? 1 : 0);
  endtask

  // Advance one clock edge, updating the model from the pre-edge inputs.
  task automatic tick();
    int wd;
    wd = load_data ? int'(count) : m_alu(alu_opcode, mr[rd_addr1], mr[rd_addr2]);
    if (rst) begin
      for (int i = 0; i < 4; i++) mr[i] = 0;
    end else if (wrt_en) begin
      mr[wrt_addr] = wd;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input int val);
    wrt_en = 1'b1; load_data = 1'b1; wrt_addr = 2'(addr); count = 4'(val);
    tick();
    wrt_en = 1'b0;
  endtask

  initial begin
    vt[0] = '{3'b000, 4'hA, 1'b0};
    vt[1] = '{3'b001, 4'h6, 1'b0};
    vt[2] = '{3'b010, 4'h2, 1'b0};
    vt[3] = '{3'b011, 4'hE, 1'b0};
    vt[4] = '{3'b100, 4'hC, 1'b0};
    vt[5] = '{3'b101, 4'h5, 1'b0};
    vt[6] = '{3'b110, 4'h0, 1'b1};
    vt[7] = '{3'b111, 4'h4, 1'b0};
    fib_exp = '{2, 3, 5, 8, 13, 5, 2, 7, 9, 0, 9, 9};
    for (int i = 0; i < 4; i++) mr[i] = 0;

    // Reset with a concurrent write that must be discarded.
    rst = 1'b1; wrt_en = 1'b1; load_data = 1'b1; count = 4'd5; wrt_addr = 2'd0;
    rd_addr1 = 2'd0; rd_addr2 = 2'd3; alu_opcode = 3'b110;
    #2;
    tick();
    rst = 1'b0; wrt_en = 1'b0;
    #1;
    chk("reset_data", data, 0);
    chk("reset_zf", zero_flag, 1);
    alu_opcode = 3'b000;
    #1;
    chk("reset_nowrite_r0", data, 0);

    // Seed load of all four registers with 1.
    for (int a = 0; a < 4; a++) load(a, 1);
    alu_opcode = 3'b000;
    for (int a = 0; a < 4; a++) begin
      rd_addr1 = 2'(a);
      #1;
      chk($sformatf("seed_r%0d_data", a), data, 1);
      chk($sformatf("seed_r%0d_zf", a), zero_flag, 0);
    end

    // Fibonacci rotation with wrap modulo 16.
    load_data = 1'b0; alu_opcode = 3'b110;
    for (int i = 0; i < 12; i++) begin
      rd_addr1 = 2'(i % 4);
      rd_addr2 = 2'((i + 3) % 4);
      wrt_addr = 2'((i + 1) % 4);
      wrt_en = 1'b1;
      #1;
      chk($sformatf("fib%0d_data", i), data, fib_exp[i]);
      chk($sformatf("fib%0d_zf", i), zero_flag, (fib_exp[i] == 0) ? 1 : 0);
      tick();
    end
    wrt_en = 1'b0;

    // Write enable low: R2 must keep its value.
    wrt_en = 1'b0; load_data = 1'b1; count = 4'd7; wrt_addr = 2'd2;
    tick();
    alu_opcode = 3'b000; rd_addr1 = 2'd2;
    #1;
    chk("wen_gate_r2", data, 0);
    chk_model("wen_gate_model");

    // Opcode sweep with A=0xA, B=0x6.
    load(0, 10);
    load(1, 6);
    rd_addr1 = 2'd0; rd_addr2 = 2'd1;
    for (int i = 0; i < 8; i++) begin
      alu_opcode = vt[i].op;
      #1;
      chk($sformatf("op%0d_data", i), data, vt[i].exp_data);
      chk($sformatf("op%0d_zf", i), zero_flag, vt[i].exp_zf);
    end

    // Read during write: old value before the edge, new value after.
    load(1, 3);
    rd_addr1 = 2'd1; alu_opcode = 3'b000;
    wrt_en = 1'b1; load_data = 1'b1; wrt_addr = 2'd1; count = 4'd9;
    #1;
    chk("rdw_before", data, 3);
    tick();
    wrt_en = 1'b0;
    #1;
    chk("rdw_after", data, 9);

    // Mid-operation reset with a concurrent write.
    rst = 1'b1; wrt_en = 1'b1; load_data = 1'b1; count = 4'd12; wrt_addr = 2'd3;
    tick();
    rst = 1'b0; wrt_en = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd_addr1 = 2'(a); alu_opcode = 3'b000;
      #1;
      chk($sformatf("midrst_r%0d", a), data, 0);
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      rst        = ($urandom_range(0, 31) == 0);
      wrt_en     = 1'($urandom);
      load_data  = 1'($urandom);
      wrt_addr   = 2'($urandom);
      rd_addr1   = 2'($urandom);
      rd_addr2   = 2'($urandom);
      alu_opcode = 3'($urandom);
      count      = 4'($urandom);
      #1;
      chk_model($sformatf("rand%0d", n));
      tick();
    end
    rst = 1'b0; wrt_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fibo_datapath.md
Name: fibo_datapath

Overview:
- Datapath for a Fibonacci-sequence generator: a 4-entry register file, a 3-bit-opcode ALU and a write-data multiplexer.
- A companion controller sequences the datapath. It first loads seed values from `count`, then repeatedly writes R[a]+R[b] back into the register file.
- Exposes the ALU result and a zero flag to the controller and the outside world.

Parameters:
- size, 4, datapath width in bits (register width, count width, data width)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high; clears register file
- wrt_addr  input  2  register-file write address
- wrt_en  input  1  write enable; 1 = write on rising clk edge
- load_data  input  1  write-data select: 1 = count, 0 = ALU result
- rd_addr1  input  2  read port 1 address (ALU operand A)
- rd_addr2  input  2  read port 2 address (ALU operand B)
- alu_opcode  input  3  ALU operation select
- count  input  size  external load value
- zero_flag  output  1  1 when ALU result == 0
- data  output  size  ALU result

Behaviour:
- Register file: 4 x size-bit registers, R0..R3.
  - On rising clk: if rst, all R* <= 0.
  - Else if wrt_en, R[wrt_addr] <= wd, where wd = load_data ? count : alu_result.
  - Else hold.
  - rst has priority over wrt_en.
- Reads:
  - Combinational, asynchronous: A = R[rd_addr1], B = R[rd_addr2].
  - Reading the address being written in the same cycle returns the old value; the new value is visible after the edge (no write-through bypass).
  - Both read ports may address the same register.
- ALU (combinational, result is size bits, all arithmetic modulo 2^size, carry/borrow discarded):
  - 000 A (pass A)
  - 001 B (pass B)
  - 010 A AND B
  - 011 A OR B
  - 100 A XOR B
  - 101 NOT A
  - 110 A + B
  - 111 A - B
- Outputs:
  - data = alu_result, combinational.
  - zero_flag = (alu_result == 0), combinational.
  - Both are independent of load_data; when load_data=1 they still reflect the ALU.
- Latency: a value written at edge N is readable and visible on data (via pass or add) immediately after edge N. This gives one Fibonacci term per clock cycle.
- After reset, all registers are 0. With any opcode, data=0 and zero_flag=1.
- Mid-operation reset: the register file clears on that edge, any concurrent write is discarded, and outputs follow combinationally.
- Unknown/X inputs need no defined handling. All opcode codes are defined, so no default case produces X.

Test Plan:
- Reset and defaults:
  - Stimulus: assert rst for one edge, then alu_opcode=110 with rd_addr1=0, rd_addr2=3.
  - Required: data=0, zero_flag=1. With wrt_en=1 and rst=1 in the same cycle, no write occurs.
- Seed load:
  - Stimulus: load_data=1, wrt_en=1, count=1, write addresses 0,1,2,3 on successive edges. Then opcode=000, sweep rd_addr1 over 0..3.
  - Required: data=1 and zero_flag=0 for every register.
- Fibonacci with wrap:
  - Stimulus: from all registers = 1, load_data=0, opcode=110, one write per edge:
    - R1 <= R0+R3, R2 <= R1+R0, R3 <= R2+R1, R0 <= R3+R2, and this rotation repeated for 12 edges.
  - Required data sequence before each edge: 2,3,5,8,13,5,2,7,9,0,9,9. These are the Fibonacci numbers mod 16.
  - zero_flag=1 exactly on the step yielding 0 (9+7=16 mod 16).
- Write enable gating:
  - Stimulus: wrt_en=0 with load_data=1, count=7, wrt_addr=2 for one edge.
  - Required: R2 unchanged.
- ALU opcode sweep:
  - Stimulus: R0=0xA, R1=0x6.
  - Required: 000 -> A, 001 -> 6, 010 -> 2, 011 -> E, 100 -> C, 101 -> 5, 110 -> 0 with zero_flag=1, 111 -> 4.
- Read-during-write:
  - Stimulus: rd_addr1=wrt_addr=1, opcode=000, load count=9 (R1 previously 3).
  - Required: data=3 before the edge, 9 after the edge.
